// File: rtl/mem_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : mem_scan_display
//  Description : Scans a data memory through its read-only port one word at
//                a time and shows the latched word as eight hex digits on a
//                multiplexed, active-low 7-segment display. The scan address
//                is loaded directly, stepped by hand, or auto-advanced.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_scan_display #(
    parameter int AWIDTH      = 12,
    parameter int REFRESH_DIV = 16,
    parameter int STEP_DIV    = 64
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              auto,
    input  logic              step,
    input  logic              ld,
    input  logic [AWIDTH-1:0] ld_addr,
    output logic [AWIDTH-1:0] extra_addr,
    input  logic [31:0]       extra_dout,
    output logic              data_valid,
    output logic [7:0]        an,
    output logic [7:0]        seg
);

    localparam int c_STEP_W = (STEP_DIV    > 1) ? $clog2(STEP_DIV)    : 1;
    localparam int c_REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_DIV - 1);
    localparam logic [c_REF_W-1:0]  c_REF_LAST  = c_REF_W'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        ST_LATCH = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t              r_state;
    logic [31:0]         r_data_reg;
    logic                r_step_q;
    logic                r_pend_ld;
    logic                r_pend_step;
    logic [AWIDTH-1:0]   r_pend_addr;
    logic [c_STEP_W-1:0] r_auto_cnt;
    logic [c_REF_W-1:0]  r_ref_cnt;
    logic [2:0]          r_index;

    logic                w_step_edge;
    logic                w_tick;
    logic [AWIDTH-1:0]   w_ld_base;
    logic [AWIDTH-1:0]   w_addr_inc;
    logic                w_ref_wrap;
    logic [2:0]          w_index_nxt;
    logic [3:0]          w_nibble;
    logic [6:0]          w_hex;
    logic                w_unused_ok;

    // Word alignment drops the low byte-address bits of the load value.
    assign w_unused_ok = &{1'b0, ld_addr[1:0]};

    assign w_step_edge = step & ~r_step_q;
    assign w_tick      = auto && (r_state == ST_SHOW) && (r_auto_cnt == c_STEP_LAST);
    assign w_ld_base   = {ld_addr[AWIDTH-1:2], 2'b00};
    // Natural modulo-2**AWIDTH wrap takes the last word back to address 0.
    assign w_addr_inc  = extra_addr + AWIDTH'(4);

    // Scan FSM: LATCH captures the memory word for one cycle, SHOW services
    // load (highest priority) then step/auto advances, queued or immediate.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_LATCH;
            extra_addr  <= '0;
            r_data_reg  <= '0;
            data_valid  <= 1'b0;
            r_pend_ld   <= 1'b0;
            r_pend_step <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    r_data_reg <= extra_dout;
                    r_state    <= ST_SHOW;
                    data_valid <= 1'b1;
                    if (ld) begin
                        r_pend_ld   <= 1'b1;
                        r_pend_addr <= w_ld_base;
                    end
                    if (w_step_edge) begin
                        r_pend_step <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (ld || r_pend_ld) begin
                        // A fresh load is newer than a queued one; any step
                        // or auto tick this cycle is dropped.
                        extra_addr  <= ld ? w_ld_base : r_pend_addr;
                        r_pend_ld   <= 1'b0;
                        r_pend_step <= 1'b0;
                        r_state     <= ST_LATCH;
                        data_valid  <= 1'b0;
                    end else if (w_step_edge || r_pend_step || w_tick) begin
                        extra_addr  <= w_addr_inc;
                        r_pend_step <= 1'b0;
                        r_state     <= ST_LATCH;
                        data_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LATCH;
                end
            endcase
        end
    end

    // Delayed copy of step for rising-edge detection.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
        end
    end

    // Auto-advance divider; frozen during LATCH, cleared whenever auto is low.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_auto_cnt <= '0;
        end else if (!auto) begin
            r_auto_cnt <= '0;
        end else if (r_state == ST_SHOW) begin
            if (r_auto_cnt == c_STEP_LAST) begin
                r_auto_cnt <= '0;
            end else begin
                r_auto_cnt <= r_auto_cnt + 1'b1;
            end
        end
    end

    assign w_ref_wrap  = (r_ref_cnt == c_REF_LAST);
    assign w_index_nxt = w_ref_wrap ? (r_index + 3'd1) : r_index;
    assign w_nibble    = r_data_reg[{w_index_nxt, 2'b00} +: 4];

    // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
    always_comb begin
        w_hex = 7'h7F;
        case (w_nibble)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    // Refresh divider and digit index; runs regardless of scan state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ref_cnt <= '0;
            r_index   <= 3'd0;
        end else begin
            r_ref_cnt <= w_ref_wrap ? '0 : (r_ref_cnt + 1'b1);
            r_index   <= w_index_nxt;
        end
    end

    // Registered display drive, built from the upcoming index so the anode
    // and segments switch on the same edge as the index itself.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an  <= 8'hFE;
            seg <= 8'hC0;
        end else begin
            an  <= ~(8'b1 << w_index_nxt);
            seg <= {1'b1, w_hex};
        end
    end

endmodule
`default_nettype wire
